alu: RTL and testbench
======================

Name:
alu

Overview:
- Registered 8-function integer ALU: two WIDTH-bit operands, a 3-bit opcode, one WIDTH-bit result plus status flags.
- Sits in the datapath as a single-cycle pipelined execute stage: operands are sampled on one clock edge and the result is presented after that edge.
- Default WIDTH is 12.

Parameters:
- WIDTH, 12, operand/result width in bits; legal range 4..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid this cycle
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B; also the shift amount for shift opcodes
- opcode  input  3  function select
- out_valid  output  1  op_c/flags hold a new result
- op_c  output  WIDTH  result
- flag_zero  output  1  op_c == 0
- flag_carry  output  1  ADD carry-out / SUB borrow
- flag_neg  output  1  op_c[WIDTH-1]
- flag_ovf  output  1  signed overflow for ADD/SUB

Behaviour:
- One clock; reset is synchronous and active-high.
- Latency is exactly 1 cycle. A rising edge with in_valid=1 registers op_c and all flags computed from that cycle's inputs, and sets out_valid=1.
- A rising edge with in_valid=0 sets out_valid=0; op_c and flags hold their previous values.
- Reset: rst=1 at the edge clears op_c, all flags and out_valid to 0. rst has priority over in_valid.
- Reset mid-stream drops the in-flight result. The first post-reset result appears one edge after in_valid is next sampled high.
- Opcodes:
  - 0 ADD: op_a+op_b, modulo 2^WIDTH.
  - 1 SUB: op_a-op_b, modulo 2^WIDTH.
  - 2 AND: op_a & op_b.
  - 3 OR: op_a | op_b.
  - 4 XOR: op_a ^ op_b.
  - 5 NOT: ~op_a; op_b ignored.
  - 6 SHL: op_a logical shift left by op_b.
  - 7 SHR: op_a logical shift right by op_b.
  - Shift amount is the full op_b value. Any op_b >= WIDTH yields 0. Vacated bits fill with 0.
- Flags:
  - flag_carry:
    - ADD: bit WIDTH of the unsigned sum.
    - SUB: 1 when op_a < op_b (unsigned).
    - All other opcodes: 0.
  - flag_ovf:
    - ADD: operands have equal sign bits and the result sign differs.
    - SUB: operand signs differ and the result sign differs from op_a.
    - All other opcodes: 0.
  - flag_zero and flag_neg are always derived from the registered op_c, after saturation when enabled.
- Operands are treated as unsigned except for flag_ovf. No internal state other than the output registers.

Optional Feature:
- Macro ALU_SATURATE_EN.
- When defined:
  - ADD with carry=1 yields all-ones (2^WIDTH-1).
  - SUB with borrow=1 yields 0.
  - flag_carry still reports the raw carry/borrow.
  - flag_ovf is unchanged (computed on the wrapped result).
- When undefined: ADD/SUB wrap modulo 2^WIDTH.
- Logic ops and shifts are unaffected in both configurations.

Test Plan:
- Reset: drive rst=1 for 2 edges with in_valid=1, ADD 0x005+0x003 -> op_c=0x000, all flags 0, out_valid=0. Release rst -> next edge op_c=0x008, out_valid=1.
- ADD wrap: 0xFFF+0x001 -> op_c=0x000, carry=1, zero=1, ovf=0 (ALU_SATURATE_EN: op_c=0xFFF, zero=0, carry=1). Also ADD 0x7FF+0x001 -> op_c=0x800, ovf=1, neg=1, carry=0.
- SUB borrow: 0x000-0x001 -> op_c=0xFFF, carry=1, neg=1 (ALU_SATURATE_EN: op_c=0x000, zero=1). Also SUB 0x800-0x001 -> op_c=0x7FF, ovf=1.
- Logic: op_a=0xF0F, op_b=0x0FF gives:
  - AND -> 0x00F
  - OR -> 0xFFF
  - XOR -> 0xFF0
  - NOT -> 0x0F0
  - carry=0 and ovf=0 for all four.
- Shifts: SHL 0x001 by 11 -> 0x800, neg=1; SHL 0x001 by 12 -> 0x000, zero=1; SHR 0x800 by 11 -> 0x001; SHR 0xFFF by 0xFFF -> 0x000.
- Valid gating / sweep:
  - Deassert in_valid for 3 cycles while changing inputs -> out_valid=0, op_c and flags frozen at the last result.
  - Sweep: op_a increments every 5 cycles, op_b every cycle, opcode every 2 cycles. Compare every registered result to a reference model with 1-cycle lag.

Source files
------------

// File: rtl/alu.sv
// Registered 8-function integer ALU: one-cycle execute stage producing op_c plus zero/carry/neg/ovf flags.
// Optional build macro ALU_SATURATE_EN clamps ADD/SUB results on carry/borrow instead of wrapping.
module alu #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] op_c,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_ovf
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             zero;
    logic             carry;
    logic             neg;
    logic             ovf;
  } result_t;

  if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
    $error("alu: WIDTH must lie in 4..32");
  end

  // Any shift amount of WIDTH or more clears every bit, whatever the upper bits of op_b hold.
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           sign_a;
  logic           sign_b;
  logic           shift_out_of_range;
  result_t        next_result;

  assign sum_ext            = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext           = {1'b0, op_a} - {1'b0, op_b};
  assign sign_a             = op_a[WIDTH-1];
  assign sign_b             = op_b[WIDTH-1];
  assign shift_out_of_range = (op_b >= SHIFT_LIMIT);

  // NOTE: every field gets a default before the case, so no path through this block can infer a latch.
  always_comb begin
    next_result = '0;
    unique case (opcode_e'(opcode))
      OP_ADD: begin
        next_result.value = sum_ext[WIDTH-1:0];
        next_result.carry = sum_ext[WIDTH];
        next_result.ovf   = (sign_a == sign_b) && (sum_ext[WIDTH-1] != sign_a);
`ifdef ALU_SATURATE_EN
        if (sum_ext[WIDTH]) next_result.value = '1;
`endif
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is set exactly when op_a < op_b.
        next_result.value = diff_ext[WIDTH-1:0];
        next_result.carry = diff_ext[WIDTH];
        next_result.ovf   = (sign_a != sign_b) && (diff_ext[WIDTH-1] != sign_a);
`ifdef ALU_SATURATE_EN
        if (diff_ext[WIDTH]) next_result.value = '0;
`endif
      end
      OP_AND: next_result.value = op_a & op_b;
      OP_OR:  next_result.value = op_a | op_b;
      OP_XOR: next_result.value = op_a ^ op_b;
      OP_NOT: next_result.value = ~op_a;
      OP_SHL: next_result.value = shift_out_of_range ? '0 : (op_a << op_b);
      OP_SHR: next_result.value = shift_out_of_range ? '0 : (op_a >> op_b);
      default: next_result = '0;
    endcase
    // Zero/neg follow the final (possibly saturated) value that lands in op_c.
    next_result.zero = (next_result.value == '0);
    next_result.neg  = next_result.value[WIDTH-1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      op_c       <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        op_c       <= next_result.value;
        flag_zero  <= next_result.zero;
        flag_carry <= next_result.carry;
        flag_neg   <= next_result.neg;
        flag_ovf   <= next_result.ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH=12): directed vector table, reset/valid-gating sequences and a model-checked sweep.
// Honours ALU_SATURATE_EN when defined for the whole compile.
module tb_alu;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   opcode;
  logic         out_valid;
  logic [W-1:0] op_c;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_neg;
  logic         flag_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .op_c       (op_c),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_neg   (flag_neg),
    .flag_ovf   (flag_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         z;
    logic         cy;
    logic         n;
    logic         v;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] c;
    logic         z;
    logic         cy;
    logic         n;
    logic         v;
  } expect_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic v_exp, input expect_t e);
    check({name, " out_valid"}, 32'(out_valid), 32'(v_exp));
    check({name, " op_c"},      32'(op_c),      32'(e.c));
    check({name, " zero"},      32'(flag_zero), 32'(e.z));
    check({name, " carry"},     32'(flag_carry), 32'(e.cy));
    check({name, " neg"},       32'(flag_neg),  32'(e.n));
    check({name, " ovf"},       32'(flag_ovf),  32'(e.v));
  endtask

  // Integer-arithmetic reference, independent of bit-level tricks.
  function automatic expect_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    expect_t r;
    int ua, ub, sa, sb, val;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2048) ? ua - 4096 : ua;
    sb = (ub >= 2048) ? ub - 4096 : ub;
    r  = '0;
    val = 0;
    case (op)
      3'd0: begin
        val  = ua + ub;
        r.cy = (val >= 4096);
        r.v  = (sa + sb > 2047) || (sa + sb < -2048);
        val  = val % 4096;
`ifdef ALU_SATURATE_EN
        if (r.cy) val = 4095;
`endif
      end
      3'd1: begin
        r.cy = (ua < ub);
        r.v  = (sa - sb > 2047) || (sa - sb < -2048);
        val  = (ua - ub + 4096) % 4096;
`ifdef ALU_SATURATE_EN
        if (r.cy) val = 0;
`endif
      end
      3'd2: val = int'(a & b);
      3'd3: val = int'(a | b);
      3'd4: val = int'(a ^ b);
      3'd5: val = 4095 - ua;
      3'd6: val = (ub >= 12) ? 0 : (ua * (1 << ub)) % 4096;
      default: val = (ub >= 12) ? 0 : ua / (1 << ub);
    endcase
    r.c = W'(val);
    r.z = (val == 0);
    r.n = (val >= 2048);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v;
    opcode   = op;
    op_a     = a;
    op_b     = b;
  endtask

  vec_t    vecs[$];
  expect_t held;
  expect_t e;
  logic [W-1:0] sa_a, sa_b;
  logic [2:0]   sa_op;

  initial begin
    // Directed vectors with hand-computed results.
`ifdef ALU_SATURATE_EN
    vecs.push_back('{"add_wrap",   3'd0, 12'hFFF, 12'h001, 12'hFFF, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"sub_borrow", 3'd1, 12'h000, 12'h001, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
`else
    vecs.push_back('{"add_wrap",   3'd0, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sub_borrow", 3'd1, 12'h000, 12'h001, 12'hFFF, 1'b0, 1'b1, 1'b1, 1'b0});
`endif
    vecs.push_back('{"add_ovf",    3'd0, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"sub_ovf",    3'd1, 12'h800, 12'h001, 12'h7FF, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"sub_equal",  3'd1, 12'h123, 12'h123, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"and",        3'd2, 12'hF0F, 12'h0FF, 12'h00F, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"or",         3'd3, 12'hF0F, 12'h0FF, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"xor",        3'd4, 12'hF0F, 12'h0FF, 12'hFF0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"not",        3'd5, 12'hF0F, 12'h0FF, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"shl_11",     3'd6, 12'h001, 12'h00B, 12'h800, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"shl_12",     3'd6, 12'h001, 12'h00C, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"shr_11",     3'd7, 12'h800, 12'h00B, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"shr_huge",   3'd7, 12'hFFF, 12'hFFF, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0});

    // Reset held for two edges with a valid ADD presented.
    rst = 1'b1; in_valid = 1'b1; opcode = 3'd0; op_a = 12'h005; op_b = 12'h003;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_outputs($sformatf("reset_%0d", i), 1'b0, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_outputs("post_reset_add", 1'b1, '{c: 12'h008, z: 1'b0, cy: 1'b0, n: 1'b0, v: 1'b0});

    // Table-driven vectors: result appears at the negedge after the sampling edge.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      check_outputs(vecs[i].name, 1'b1,
                    '{c: vecs[i].c, z: vecs[i].z, cy: vecs[i].cy, n: vecs[i].n, v: vecs[i].v});
    end

    // Valid gating: outputs freeze at the last result while inputs keep moving.
    drive(1'b1, 3'd0, 12'h7FF, 12'h001);
    held = '{c: 12'h800, z: 1'b0, cy: 1'b0, n: 1'b1, v: 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'(i + 1), 12'(12'h111 * (i + 1)), 12'(12'h0F0 + i));
      @(posedge clk); #1;
      check_outputs($sformatf("gated_%0d", i), 1'b0, held);
    end

    // Mid-stream reset drops the in-flight result.
    drive(1'b1, 3'd3, 12'hA50, 12'h00A);
    rst = 1'b1;
    @(negedge clk);
    check_outputs("midreset_drop", 1'b0, '0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_outputs("midreset_idle", 1'b0, '0);
    in_valid = 1'b1;
    @(negedge clk);
    check_outputs("midreset_first", 1'b1, '{c: 12'hA5A, z: 1'b0, cy: 1'b0, n: 1'b1, v: 1'b0});

    // Sweep: op_a every 5 cycles, op_b every cycle, opcode every 2 cycles.
    sa_a = 12'h7FA; sa_b = 12'h000; sa_op = 3'd0;
    for (int i = 0; i < 320; i++) begin
      if (i != 0 && i % 5 == 0) sa_a = sa_a + 12'd1;
      if (i != 0 && i % 2 == 0) sa_op = sa_op + 3'd1;
      if (i != 0) sa_b = sa_b + 12'd1;
      if (i == 160) sa_a = 12'hFF8;
      drive(1'b1, sa_op, sa_a, sa_b + ((i >= 160) ? 12'hFF0 : 12'h000));
      e = model(sa_op, op_a, op_b);
      @(negedge clk);
      n_checks++;
      if ({out_valid, op_c, flag_zero, flag_carry, flag_neg, flag_ovf} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL sweep_%0d op=%0d a=0x%0h b=0x%0h: got v=%0b c=0x%0h z%0b c%0b n%0b v%0b, expected c=0x%0h z%0b c%0b n%0b v%0b",
                 i, sa_op, op_a, op_b, out_valid, op_c, flag_zero, flag_carry, flag_neg, flag_ovf,
                 e.c, e.z, e.cy, e.n, e.v);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
